// File: rtl/mc6809_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mc6809_pkg
//  Description : Shared constants for mc6809 bus peripherals: register
//                offsets of the interval timer and CTRL/STATUS bit indices.
//  Revision    : 1.0 - initial release
// ============================================================================
package mc6809_pkg;

    // Register offsets within the 8-byte timer window
    localparam logic [2:0] REG_CTRL     = 3'd0;
    localparam logic [2:0] REG_STATUS   = 3'd1;
    localparam logic [2:0] REG_LATCH_HI = 3'd2;
    localparam logic [2:0] REG_LATCH_LO = 3'd3;
    localparam logic [2:0] REG_COUNT_HI = 3'd4;
    localparam logic [2:0] REG_COUNT_LO = 3'd5;
    localparam logic [2:0] REG_CMD      = 3'd6;

    // CTRL bit indices
    localparam int CTRL_EN      = 0;
    localparam int CTRL_AUTO    = 1;
    localparam int CTRL_IEN     = 2;
    localparam int CTRL_FSEL    = 3;
    localparam int CTRL_PSC_LSB = 4;
    localparam int CTRL_PSC_MSB = 6;

    // STATUS bit indices
    localparam int STATUS_EXP   = 0;
    localparam int STATUS_OVR   = 1;

endpackage : mc6809_pkg
`default_nettype wire

// File: rtl/mc6809_bus_decode.sv
`default_nettype none
// ============================================================================
//  Module      : mc6809_bus_decode
//  Description : Address window compare and read/write strobe generation
//                for an 8-byte responder on the mc6809 CPU bus.
//  Ports       : addr_i    CPU address bus
//                rnw_i     1 = read, 0 = write
//                bus_en_i  one-CLK valid bus cycle strobe
//                sel_o     address falls inside the window
//                reg_o     register offset (ADDR[2:0])
//                rd_o/wr_o qualified read / write strobes
//  Revision    : 1.0 - initial release
// ============================================================================
module mc6809_bus_decode #(
    parameter logic [15:0] BASE_ADDR = 16'hFF00,
    parameter logic [15:0] ADDR_MASK = 16'hFFF8
) (
    input  logic [15:0] addr_i,
    input  logic        rnw_i,
    input  logic        bus_en_i,
    output logic        sel_o,
    output logic [2:0]  reg_o,
    output logic        rd_o,
    output logic        wr_o
);

    assign sel_o = ((addr_i & ADDR_MASK) == BASE_ADDR);
    assign reg_o = addr_i[2:0];
    assign rd_o  = bus_en_i & sel_o & rnw_i;
    assign wr_o  = bus_en_i & sel_o & ~rnw_i;

endmodule : mc6809_bus_decode
`default_nettype wire

// File: rtl/mc6809_bus_timer.sv
`default_nettype none
// ============================================================================
//  Module      : mc6809_bus_timer
//  Description : Memory-mapped 16-bit programmable interval timer on the
//                mc6809 CPU bus, with 2^PSC prescaler, one-shot/auto-reload
//                modes and IRQ/FIRQ routing.
//  Ports       : CLK, RESET      clock, async active-high reset
//                ADDR, RnW       CPU address and direction
//                DIN, BUS_EN     CPU write data, valid bus cycle strobe
//                DOUT, DOE       read data and read-enable (combinational)
//                nIRQ, nFIRQ     registered active-low interrupt requests
//  Revision    : 1.0 - initial release
// ============================================================================
module mc6809_bus_timer
    import mc6809_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR   = 16'hFF00,
    parameter logic [15:0] ADDR_MASK   = 16'hFFF8,
    parameter logic [15:0] RESET_LATCH = 16'hFFFF
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [15:0] ADDR,
    input  logic [7:0]  DIN,
    input  logic        RnW,
    input  logic        BUS_EN,
    output logic [7:0]  DOUT,
    output logic        DOE,
    output logic        nIRQ,
    output logic        nFIRQ
);

    logic       sel;
    logic [2:0] bus_reg;
    logic       rd;
    logic       wr;

    mc6809_bus_decode #(
        .BASE_ADDR (BASE_ADDR),
        .ADDR_MASK (ADDR_MASK)
    ) u_decode (
        .addr_i   (ADDR),
        .rnw_i    (RnW),
        .bus_en_i (BUS_EN),
        .sel_o    (sel),
        .reg_o    (bus_reg),
        .rd_o     (rd),
        .wr_o     (wr)
    );

    logic [6:0]  ctrl_q,   ctrl_d;
    logic        exp_q,    exp_d;
    logic        ovr_q,    ovr_d;
    logic [7:0]  hi_buf_q, hi_buf_d;
    logic [15:0] latch_q,  latch_d;
    logic [15:0] cnt_q,    cnt_d;
    logic [7:0]  snap_q,   snap_d;
    logic [6:0]  pre_q,    pre_d;
    logic        nirq_q;
    logic        nfirq_q;

    // CTRL bit 7 does not exist
    logic unused_din7;
    assign unused_din7 = DIN[7];

    logic       en;
    logic       auto_rl;
    logic       ien;
    logic       fsel;
    logic [2:0] psc;
    logic [6:0] psc_mask;
    logic       tick;
    logic       wr_ctrl, wr_status, wr_hi, wr_lo, wr_cmd;
    logic       load;
    logic       ctrl_stop;
    logic       tick_eff;
    logic       expire;
    logic       irq;

    assign en      = ctrl_q[CTRL_EN];
    assign auto_rl = ctrl_q[CTRL_AUTO];
    assign ien     = ctrl_q[CTRL_IEN];
    assign fsel    = ctrl_q[CTRL_FSEL];
    assign psc     = ctrl_q[CTRL_PSC_MSB:CTRL_PSC_LSB];

    // PSC = 7 wraps the shift to zero, giving an all-ones mask (divide by 128)
    assign psc_mask = (7'd1 << psc) - 7'd1;
    assign tick     = en & ((pre_q & psc_mask) == psc_mask);

    assign wr_ctrl   = wr & (bus_reg == REG_CTRL);
    assign wr_status = wr & (bus_reg == REG_STATUS);
    assign wr_hi     = wr & (bus_reg == REG_LATCH_HI);
    assign wr_lo     = wr & (bus_reg == REG_LATCH_LO);
    assign wr_cmd    = wr & (bus_reg == REG_CMD);

    // A counter load or a CTRL write that stops the timer both pre-empt
    // the tick of the same cycle, including its expiry.
    assign load      = (wr_lo & ~en) | (wr_cmd & DIN[0]);
    assign ctrl_stop = wr_ctrl & ~DIN[CTRL_EN];
    assign tick_eff  = tick & ~load & ~ctrl_stop;
    assign expire    = tick_eff & (cnt_q == 16'd0);
    assign irq       = exp_q & ien;

    always_comb begin
        ctrl_d   = ctrl_q;
        hi_buf_d = hi_buf_q;
        latch_d  = latch_q;
        cnt_d    = cnt_q;
        snap_d   = snap_q;
        pre_d    = en ? (pre_q + 7'd1) : 7'd0;

        if (expire && !auto_rl) begin
            ctrl_d[CTRL_EN] = 1'b0;
        end
        if (wr_ctrl) begin
            ctrl_d = DIN[6:0];
        end

        if (wr_hi) begin
            hi_buf_d = DIN;
        end
        if (wr_lo) begin
            latch_d = {hi_buf_q, DIN};
        end

        if (load) begin
            cnt_d = wr_lo ? {hi_buf_q, DIN} : latch_q;
            pre_d = 7'd0;
        end else if (tick_eff) begin
            if (cnt_q != 16'd0) begin
                cnt_d = cnt_q - 16'd1;
            end else if (auto_rl) begin
                cnt_d = latch_q;
            end
        end

        // Snapshot the low byte so a HI-then-LO read pair is coherent
        if (rd && (bus_reg == REG_COUNT_HI)) begin
            snap_d = cnt_q[7:0];
        end

        // Set has priority over write-one-to-clear
        exp_d = expire | (exp_q & ~(wr_status & DIN[STATUS_EXP]));
        ovr_d = (expire & exp_q) | (ovr_q & ~(wr_status & DIN[STATUS_OVR]));
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            ctrl_q   <= 7'd0;
            exp_q    <= 1'b0;
            ovr_q    <= 1'b0;
            hi_buf_q <= 8'd0;
            latch_q  <= RESET_LATCH;
            cnt_q    <= RESET_LATCH;
            snap_q   <= 8'd0;
            pre_q    <= 7'd0;
            nirq_q   <= 1'b1;
            nfirq_q  <= 1'b1;
        end else begin
            ctrl_q   <= ctrl_d;
            exp_q    <= exp_d;
            ovr_q    <= ovr_d;
            hi_buf_q <= hi_buf_d;
            latch_q  <= latch_d;
            cnt_q    <= cnt_d;
            snap_q   <= snap_d;
            pre_q    <= pre_d;
            nirq_q   <= ~(irq & ~fsel);
            nfirq_q  <= ~(irq & fsel);
        end
    end

    assign nIRQ  = nirq_q;
    assign nFIRQ = nfirq_q;
    assign DOE   = sel & RnW;

    always_comb begin
        DOUT = 8'h00;
        if (sel && RnW) begin
            case (bus_reg)
                REG_CTRL:     DOUT = {1'b0, ctrl_q};
                REG_STATUS:   DOUT = {6'd0, ovr_q, exp_q};
                REG_LATCH_HI: DOUT = hi_buf_q;
                REG_LATCH_LO: DOUT = latch_q[7:0];
                REG_COUNT_HI: DOUT = cnt_q[15:8];
                REG_COUNT_LO: DOUT = snap_q;
                default:      DOUT = 8'h00;
            endcase
        end
    end

endmodule : mc6809_bus_timer
`default_nettype wire
